// File: rtl/seg_scan_encoder.sv
// rtl/seg_scan_encoder.sv - recovers hex digits from a scanned active-low 7-segment bus
// Synchronize, qualify each digit by stability, check scan order, emit frames over valid/ready.
module seg_scan_encoder #(
  parameter int N_DIGITS    = 4,
  parameter int STABLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n_in,
  input  logic [N_DIGITS-1:0]   an_n_in,
  output logic [4*N_DIGITS-1:0] frame_digits,
  output logic [N_DIGITS-1:0]   frame_invalid,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  seq_err,
  output logic                  overrun
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW = N_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYC);

  typedef enum logic [0:0] {WAIT_FIRST, COLLECT} state_t;

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] samp;
  logic [SW-1:0] prev_q;
  logic [N_DIGITS-1:0] an_lo;
  logic eligible;
  logic same;
  logic strobe;
  logic [CW-1:0] cnt_q;

  logic [IW-1:0] samp_idx;
  logic [4:0] samp_dec;

  logic cap_vld_q;
  logic [IW-1:0] cap_idx_q;
  logic [3:0] cap_nib_q;
  logic cap_inv_q;

  state_t state_q, state_d;
  logic [IW-1:0] exp_q, exp_d;
  logic [4*N_DIGITS-1:0] part_q, part_d;
  logic [N_DIGITS-1:0] part_inv_q, part_inv_d;
  logic [4*N_DIGITS-1:0] merged;
  logic [N_DIGITS-1:0] merged_inv;
  logic done;
  logic seq_err_d;

  // Returns {invalid, nibble}; patterns are active-low with bit6=g.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {an_n_in, seg_n_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign samp     = sync_q[SYNC_STAGES-1];
  assign an_lo    = ~samp[SW-1:7];
  assign eligible = (an_lo != '0) && ((an_lo & (an_lo - 1'b1)) == '0);
  assign same     = (samp == prev_q);
  // Counter saturates one past the strobe value so a held digit captures only once.
  assign strobe   = eligible && same && (cnt_q == CW'(STABLE_CYC - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      prev_q <= samp;
      if (eligible && same) begin
        if (cnt_q != CW'(STABLE_CYC - 1)) cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    samp_idx = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (an_lo[k]) samp_idx = IW'(k);
    end
  end

  assign samp_dec = seg_decode(samp[6:0]);

  // Nibbles are stored bit-reversed: bit 4k of the frame carries the nibble MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      cap_nib_q <= '0;
      cap_inv_q <= 1'b0;
    end else begin
      cap_vld_q <= strobe;
      if (strobe) begin
        cap_idx_q <= samp_idx;
        cap_nib_q <= {samp_dec[0], samp_dec[1], samp_dec[2], samp_dec[3]};
        cap_inv_q <= samp_dec[4];
      end
    end
  end

  always_comb begin
    merged = part_q;
    merged_inv = part_inv_q;
    merged[4*int'(cap_idx_q) +: 4] = cap_nib_q;
    merged_inv[cap_idx_q] = cap_inv_q;
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    part_d     = part_q;
    part_inv_d = part_inv_q;
    done       = 1'b0;
    seq_err_d  = 1'b0;
    case (state_q)
      WAIT_FIRST: begin
        if (cap_vld_q && (cap_idx_q == '0)) begin
          part_d     = merged;
          part_inv_d = merged_inv;
          exp_d      = IW'(1);
          if (N_DIGITS == 1) done = 1'b1;
          else state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (cap_vld_q) begin
          if (cap_idx_q == exp_q) begin
            part_d     = merged;
            part_inv_d = merged_inv;
            if (exp_q == IW'(N_DIGITS - 1)) begin
              done    = 1'b1;
              state_d = WAIT_FIRST;
            end else begin
              exp_d = exp_q + IW'(1);
            end
          end else begin
            seq_err_d = 1'b1;
            if (cap_idx_q == '0) begin
              part_d     = merged;
              part_inv_d = merged_inv;
              exp_d      = IW'(1);
            end else begin
              state_d = WAIT_FIRST;
            end
          end
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_FIRST;
      exp_q      <= '0;
      part_q     <= '0;
      part_inv_q <= '0;
      seq_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      part_q     <= part_d;
      part_inv_q <= part_inv_d;
      seq_err    <= seq_err_d;
    end
  end

  // A completing frame is only dropped when the held one has not been taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_digits  <= '0;
      frame_invalid <= '0;
      frame_valid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!frame_valid || frame_ready) begin
          frame_digits  <= merged;
          frame_invalid <= merged_inv;
          frame_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_encoder.sv
// tb/tb_seg_scan_encoder.sv - directed scoreboard bench for seg_scan_encoder
// Expected frames are queued as scans are driven and checked at each handshake.
module tb_seg_scan_encoder;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_n_in;
  logic [3:0]  an_n_in;
  logic [15:0] frame_digits;
  logic [3:0]  frame_invalid;
  logic        frame_valid;
  logic        frame_ready;
  logic        seq_err;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int seq_cnt = 0;
  int ovr_cnt = 0;
  int hs_cnt = 0;
  int seq_base;
  int ovr_base;
  int hs_base;
  logic [19:0] sbq [$];
  logic [19:0] exp_a;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_encoder #(.N_DIGITS(4), .STABLE_CYC(8), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .seg_n_in(seg_n_in),
    .an_n_in(an_n_in),
    .frame_digits(frame_digits),
    .frame_invalid(frame_invalid),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .seq_err(seq_err),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] rv(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [19:0] frame_of(input logic [3:0] d0, input logic [3:0] d1,
                                           input logic [3:0] d2, input logic [3:0] d3);
    return {4'b0000, rv(d3), rv(d2), rv(d1), rv(d0)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic show(input int k, input logic [6:0] p, input int n);
    an_n_in  = ~(4'b0001 << k);
    seg_n_in = p;
    step(n);
  endtask

  task automatic scan4(input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3);
    show(0, pat[d0], 20);
    show(1, pat[d1], 20);
    show(2, pat[d2], 20);
    show(3, pat[d3], 20);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (seq_err) seq_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_valid && frame_ready) begin
        logic [19:0] want;
        hs_cnt++;
        total++;
        assert (sbq.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_frame got=%0h exp=none", {frame_invalid, frame_digits});
        end
        if (sbq.size() != 0) begin
          want = sbq.pop_front();
          total++;
          assert ({frame_invalid, frame_digits} === want) else begin
            bad++;
            $error("FAIL frame got=%0h exp=%0h", {frame_invalid, frame_digits}, want);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    frame_ready = 1'b1;
    an_n_in = 4'hF;
    seg_n_in = 7'h7F;

    // reset with a toggling bus
    for (int i = 0; i < 3; i++) begin
      an_n_in  = 4'($urandom);
      seg_n_in = 7'($urandom);
      step(1);
    end
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_digits", 32'(frame_digits), 32'd0);
    chk("rst_invalid", 32'(frame_invalid), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    an_n_in = 4'hF;
    seg_n_in = 7'h7F;
    rst = 1'b0;
    step(2);

    // clean scan with exact latency on the last digit
    show(0, 7'h79, 12);
    chk("valid_after_d0_hold", 32'(frame_valid), 32'd0);
    step(8);
    show(1, 7'h24, 20);
    show(2, 7'h30, 20);
    sbq.push_back({4'b0000, 16'h2C48});
    hs_base = hs_cnt;
    show(3, 7'h19, 10);
    chk("latency_t10", 32'(frame_valid), 32'd0);
    step(1);
    chk("latency_t11", 32'(frame_valid), 32'd1);
    chk("clean_digits", 32'(frame_digits), 32'h2C48);
    step(1);
    chk("valid_one_cycle", 32'(frame_valid), 32'd0);
    step(8);
    chk("clean_handshakes", 32'(hs_cnt - hs_base), 32'd1);

    // glitch on digit 1 restarts its stability window only
    seq_base = seq_cnt;
    sbq.push_back(frame_of(4'd5, 4'd6, 4'd7, 4'd8));
    show(0, pat[5], 20);
    show(1, pat[6], 5);
    an_n_in = 4'hF;
    step(1);
    show(1, pat[6], 20);
    show(2, pat[7], 20);
    show(3, pat[8], 20);
    chk("glitch_seq_err", 32'(seq_cnt - seq_base), 32'd0);

    // all-segments-off is not a hex glyph
    sbq.push_back({4'b0100, rv(4'hB), 4'h0, rv(4'hA), rv(4'h9)});
    show(0, pat[9], 20);
    show(1, pat[10], 20);
    show(2, 7'h7F, 20);
    show(3, pat[11], 20);
    chk("invalid_mask_held", 32'(frame_invalid), 32'h4);
    chk("invalid_nibble", 32'(frame_digits[11:8]), 32'd0);

    // out-of-order digit aborts the frame, next full scan recovers
    seq_base = seq_cnt;
    hs_base = hs_cnt;
    show(0, pat[0], 20);
    show(1, pat[1], 20);
    show(3, pat[3], 20);
    chk("order_seq_err", 32'(seq_cnt - seq_base), 32'd1);
    chk("order_no_frame", 32'(hs_cnt - hs_base), 32'd0);
    sbq.push_back(frame_of(4'hC, 4'hD, 4'hE, 4'hF));
    scan4(4'hC, 4'hD, 4'hE, 4'hF);
    chk("recover_frame", 32'(hs_cnt - hs_base), 32'd1);

    // backpressure: second frame dropped, first held
    frame_ready = 1'b0;
    ovr_base = ovr_cnt;
    exp_a = frame_of(4'h8, 4'h9, 4'hA, 4'hB);
    sbq.push_back(exp_a);
    scan4(4'h8, 4'h9, 4'hA, 4'hB);
    chk("bp_valid_a", 32'(frame_valid), 32'd1);
    chk("bp_frame_a", 32'({frame_invalid, frame_digits}), 32'(exp_a));
    scan4(4'h1, 4'h3, 4'h5, 4'h7);
    chk("bp_overrun", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("bp_valid_held", 32'(frame_valid), 32'd1);
    chk("bp_frame_held", 32'({frame_invalid, frame_digits}), 32'(exp_a));
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    chk("bp_release", 32'(frame_valid), 32'd0);
    chk("bp_digits_kept", 32'(frame_digits), 32'(exp_a[15:0]));
    frame_ready = 1'b1;
    step(2);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("total_handshakes", 32'(hs_cnt), 32'd5);
    chk("total_seq_err", 32'(seq_cnt), 32'd1);
    chk("total_overrun", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
